// File: rtl/pingpong_vector_buffer_pkg.sv
// Shared defaults and helpers for the ping-pong vector buffer.
package pingpong_vector_buffer_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 32;
    localparam int unsigned NUM_BANKS  = 2;

    // Address width for n entries, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pingpong_vector_buffer_if.sv
// Producer/consumer bus of the ping-pong vector buffer.
interface pingpong_vector_buffer_if
    import pingpong_vector_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
);
    localparam int unsigned ADDR_W = clog2_min1(DEPTH);

    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              vec_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_release;
    logic [ADDR_W-1:0] wr_count;
    logic [1:0]        full_banks;

    // Environment side: producer, consumer and flush control.
    modport master (
        output flush, in_valid, in_data, rd_en, rd_addr, rd_release,
        input  in_ready, vec_ready, rd_data, rd_valid, wr_count, full_banks
    );

    // Buffer side.
    modport slave (
        input  flush, in_valid, in_data, rd_en, rd_addr, rd_release,
        output in_ready, vec_ready, rd_data, rd_valid, wr_count, full_banks
    );

endinterface

// File: rtl/pvb_bank_ram.sv
// One bank: DEPTH x DATA_W array, one write port, one registered read port.
module pvb_bank_ram
    import pingpong_vector_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clr,
    input  logic                           we,
    input  logic [clog2_min1(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic                           re,
    input  logic [clog2_min1(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; cleared so the output is defined after reset/flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pingpong_vector_buffer.sv
// Two-bank vector buffer: serial fill of one bank while the other is read.
module pingpong_vector_buffer
    import pingpong_vector_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
)(
    input  logic                    clk,
    input  logic                    reset,
    pingpong_vector_buffer_if.slave bus
);

    localparam int unsigned ADDR_W = clog2_min1(DEPTH);

    logic [NUM_BANKS-1:0] bank_full;
    logic [NUM_BANKS-1:0] bank_full_nxt;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [ADDR_W-1:0]    wr_cnt;
    logic                 rd_valid_q;
    logic                 rd_sel_q;
    logic                 rd_oob_q;

    logic                 in_ready_c;
    logic                 vec_ready_c;
    logic                 accept;
    logic                 wr_last;
    logic                 rd_accept;
    logic                 release_ok;
    logic                 addr_oob;

    logic [NUM_BANKS-1:0] bank_we;
    logic [NUM_BANKS-1:0] bank_re;
    logic [DATA_W-1:0]    bank_q [NUM_BANKS];

    // Handshake qualifiers; flush overrides every request in its cycle.
    assign in_ready_c  = !bank_full[wr_bank];
    assign vec_ready_c = bank_full[rd_bank];
    assign accept      = bus.in_valid && in_ready_c && !bus.flush;
    assign wr_last     = accept && (wr_cnt == ADDR_W'(DEPTH - 1));
    assign rd_accept   = bus.rd_en && vec_ready_c && !bus.flush;
    assign release_ok  = bus.rd_release && vec_ready_c && !bus.flush;

    // Out-of-range read addresses only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (2 ** ADDR_W)) begin : g_pow2
            assign addr_oob = 1'b0;
        end else begin : g_npow2
            assign addr_oob = (32'(bus.rd_addr) >= DEPTH);
        end
    endgenerate

    // Fill and release touch different banks, so both can apply together.
    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_last) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
        if (release_ok) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
    end

    // Pointers, write counter and read-side status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_full  <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else if (bus.flush) begin
            bank_full  <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else begin
            bank_full  <= bank_full_nxt;
            rd_valid_q <= rd_accept;
            if (accept) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + ADDR_W'(1);
            end
            if (wr_last) begin
                wr_bank <= ~wr_bank;
            end
            if (release_ok) begin
                rd_bank <= ~rd_bank;
            end
            if (rd_accept) begin
                rd_sel_q <= rd_bank;
                rd_oob_q <= addr_oob;
            end
        end
    end

    // Bank instances; only the addressed bank's read register updates.
    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign bank_we[b] = accept && (wr_bank == 1'(b));
            assign bank_re[b] = rd_accept && !addr_oob && (rd_bank == 1'(b));

            pvb_bank_ram #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_bank (
                .clk    (clk),
                .reset  (reset),
                .clr    (bus.flush),
                .we     (bank_we[b]),
                .waddr  (wr_cnt),
                .wdata  (bus.in_data),
                .re     (bank_re[b]),
                .raddr  (bus.rd_addr),
                .rdata  (bank_q[b])
            );
        end
    endgenerate

    // Output mapping.
    assign bus.in_ready   = in_ready_c;
    assign bus.vec_ready  = vec_ready_c;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_oob_q ? '0 : bank_q[rd_sel_q];
    assign bus.wr_count   = wr_cnt;
    assign bus.full_banks = {1'b0, bank_full[0]} + {1'b0, bank_full[1]};

endmodule
